// File: rtl/qoi_pix_decoder.sv
// QOI-style byte stream to {r,g,b} pixel decoder with an internal colour index table.
// Latency: pixel valid the cycle after an op's last byte; one byte or one pixel per cycle.
// Backpressure: pix_ready low holds the pixel and blocks input; en low freezes all handshakes.
module qoi_pix_decoder #(
    parameter int CW    = 4,
    parameter int IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3*CW-1:0] pix_data,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            done,
    output logic            busy
);
    localparam int PW    = 3 * CW;
    localparam int DEPTH = 1 << IDX_W;
    localparam int LIT_B = (PW + 7) / 8;

    typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_EMIT, S_RUN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   prev, pix_r;
    logic [PW-1:0]   index_tbl [DEPTH];
    logic [PW-9:0]   lit_acc;
    logic [1:0]      arg_cnt;
    logic            arg_rgb;
    logic [5:0]      luma_g;
    logic [5:0]      run_cnt;

    logic            go, in_fire, pix_fire, arg_last;
    logic [PW-1:0]   lit_nx, diff_pix, luma_pix;
    logic [9:0]      dg, dr, db;

    // Deltas are carried in 10-bit two's complement; keeping the low CW bits gives the wrap.
    function automatic logic [CW-1:0] add_d(input logic [CW-1:0] c, input logic [9:0] d);
        logic [9:0] s;
        s = 10'(c) + d;
        return s[CW-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] hash(input logic [PW-1:0] p);
        logic [11:0] s;
        s = 12'(p[PW-1 -: CW]) * 12'd3 + 12'(p[2*CW-1 -: CW]) * 12'd5 + 12'(p[CW-1:0]) * 12'd7;
        return s[IDX_W-1:0];
    endfunction

    assign go       = en & start;
    assign in_fire  = in_valid & in_ready;
    assign pix_fire = pix_valid & pix_ready;
    assign arg_last = !arg_rgb || (arg_cnt == 2'(LIT_B - 1));
    assign lit_nx   = {lit_acc, in_data};

    always_comb begin
        dg       = 10'({4'b0, luma_g}) - 10'd32;
        dr       = dg + 10'({6'b0, in_data[7:4]}) - 10'd8;
        db       = dg + 10'({6'b0, in_data[3:0]}) - 10'd8;
        luma_pix = {add_d(prev[PW-1 -: CW], dr), add_d(prev[2*CW-1 -: CW], dg),
                    add_d(prev[CW-1:0], db)};
        diff_pix = {add_d(prev[PW-1 -: CW],   10'({8'b0, in_data[5:4]}) - 10'd2),
                    add_d(prev[2*CW-1 -: CW], 10'({8'b0, in_data[3:2]}) - 10'd2),
                    add_d(prev[CW-1:0],       10'({8'b0, in_data[1:0]}) - 10'd2)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (go) begin
            state_nx = S_OP;
        end else begin
            case (state)
                S_OP: if (in_fire) begin
                    if (in_data == 8'hFE)          state_nx = S_ARG;
                    else if (in_data == 8'hFF)     state_nx = S_DONE;
                    else if (in_data[7:6] == 2'b11) state_nx = S_RUN;
                    else if (in_data[7:6] == 2'b10) state_nx = S_ARG;
                    else                           state_nx = S_EMIT;
                end
                S_ARG:  if (in_fire && arg_last) state_nx = S_EMIT;
                S_EMIT: if (pix_fire) state_nx = S_OP;
                S_RUN:  if (pix_fire && run_cnt == 6'd1) state_nx = S_OP;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        in_ready  = en && (state == S_OP || state == S_ARG);
        pix_valid = en && (state == S_EMIT || state == S_RUN);
        pix_data  = pix_r;
        done      = (state == S_DONE);
        busy      = (state != S_IDLE) && (state != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            pix_r   <= '0;
            lit_acc <= '0;
            arg_cnt <= '0;
            arg_rgb <= 1'b0;
            luma_g  <= '0;
            run_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) index_tbl[i] <= '0;
        end else if (go) begin
            prev    <= '0;
            pix_r   <= '0;
            arg_cnt <= '0;
            run_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) index_tbl[i] <= '0;
        end else begin
            if (in_fire && state == S_OP) begin
                arg_cnt <= '0;
                if (in_data == 8'hFE) begin
                    arg_rgb <= 1'b1;
                end else if (in_data == 8'hFF) begin
                    arg_rgb <= 1'b0;
                end else if (in_data[7:6] == 2'b11) begin
                    run_cnt <= in_data[5:0] + 6'd1;
                    pix_r   <= prev;
                end else if (in_data[7:6] == 2'b10) begin
                    arg_rgb <= 1'b0;
                    luma_g  <= in_data[5:0];
                end else if (in_data[6]) begin
                    pix_r <= diff_pix;
                end else begin
                    pix_r <= index_tbl[in_data[IDX_W-1:0]];
                end
            end
            if (in_fire && state == S_ARG) begin
                if (arg_rgb) begin
                    lit_acc <= lit_nx[PW-9:0];
                    arg_cnt <= arg_cnt + 2'd1;
                    if (arg_last) pix_r <= lit_nx;
                end else begin
                    pix_r <= luma_pix;
                end
            end
            if (pix_fire) begin
                prev                  <= pix_r;
                index_tbl[hash(pix_r)] <= pix_r;
                if (state == S_RUN) run_cnt <= run_cnt - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_qoi_pix_decoder.sv
// Directed stream bench for qoi_pix_decoder (CW=4, IDX_W=6) with a queue-based pixel scoreboard.
module tb_qoi_pix_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [11:0] held = '0;

    qoi_pix_decoder #(.CW(4), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every pixel handshake and checks stall stability.
    always @(negedge clk) begin
        if (pix_valid) begin
            if (stalled) chk("stall_hold", {20'b0, pix_data}, {20'b0, held});
            chk("no_byte_while_pending", {31'b0, in_ready}, 32'd0);
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
            end else begin
                chk("pixel", {20'b0, pix_data}, {20'b0, exp_q.pop_front()});
            end
        end
        stalled = pix_valid && !pix_ready;
        held    = pix_data;
    end

    // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit exp_pix);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_pix) begin
            chk("latency_valid", {31'b0, pix_valid}, 32'd1);
            chk("latency_in_ready", {31'b0, in_ready}, 32'd0);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || pix_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pix_data", {20'b0, pix_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd0);
        pulse_start();
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_in_ready", {31'b0, in_ready}, 32'd1);

        // RGB literal
        exp_q.push_back(12'hFA5);
        send_byte(8'hFE, 0);
        send_byte(8'h0F, 0);
        send_byte(8'hA5, 1);
        drain();

        // DIFF +1,0,-1 with red wrap
        exp_q.push_back(12'h0A4);
        send_byte(8'h79, 1);
        drain();

        // LUMA dg=+2 dr=+3 db=+1
        exp_q.push_back(12'h3C5);
        send_byte(8'hA2, 0);
        send_byte(8'h97, 1);
        drain();

        // RUN of three with a one-cycle stall
        repeat (3) exp_q.push_back(12'h3C5);
        send_byte(8'hC2, 1);
        pix_ready = 1'b0;
        @(posedge clk); #1;
        pix_ready = 1'b1;
        drain();

        // INDEX lookups
        exp_q.push_back(12'hFA5);
        send_byte(8'h02, 1);
        drain();
        exp_q.push_back(12'h3C5);
        send_byte(8'h28, 1);
        drain();

        // RUN of two frozen by en=0
        repeat (2) exp_q.push_back(12'h3C5);
        send_byte(8'hC1, 1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("en0_pix_valid", {31'b0, pix_valid}, 32'd0);
            chk("en0_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("en0_pending", exp_q.size(), 32'd2);
        en = 1'b1;
        drain();

        // End of frame
        send_byte(8'hFF, 0);
        chk("eof_done", {31'b0, done}, 32'd1);
        chk("eof_busy", {31'b0, busy}, 32'd0);
        chk("eof_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("done_held", {31'b0, done}, 32'd1);

        // New frame: index cleared
        pulse_start();
        chk("restart_done", {31'b0, done}, 32'd0);
        exp_q.push_back(12'h000);
        send_byte(8'h02, 1);
        drain();
        exp_q.push_back(12'h10F);
        send_byte(8'h79, 1);
        drain();

        // Async reset in the middle of a literal
        send_byte(8'hFE, 0);
        send_byte(8'h12, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("arst_pix_valid", {31'b0, pix_valid}, 32'd0);
        chk("arst_pix_data", {20'b0, pix_data}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qoi_pix_decoder.md
Name: qoi_pix_decoder

Overview:
- Parametrised successor to the fixed RGB444 QOI decoder.
- Consumes a QOI-style byte stream over a valid/ready input and emits decoded pixels of 3×CW bits over a valid/ready output.
- Owns its colour index table internally; the caller no longer supplies stack_ind/rgbstack lookups.
- Sits between the frame-buffer/SPI byte reader and the display/pixel sink.

Parameters:
- CW, 4, bits per colour channel (legal 4..8); pixel = {r,g,b}, 3*CW bits.
- IDX_W, 6, index address width (legal 2..6); table depth 2**IDX_W.
- LIT_B, ceil(3*CW/8), derived localparam: literal payload bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when low, no handshake completes and all state holds
- start  in  1  one-cycle pulse: clear index/prev pixel/done, begin a frame
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts byte
- pix_data  out  3*CW  decoded pixel {r,g,b}
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  sink accepts pixel
- done  out  1  end-of-frame marker consumed; held until start or reset
- busy  out  1  frame in progress (start seen, done not yet set)

Behaviour:
- Reset (async): state=IDLE; pix_valid=0, pix_data=0, in_ready=0, done=0, busy=0; prev pixel=0; all index entries=0.
- Transfers occur only when en=1. en=0 forces in_ready=0 and pix_valid=0 at the ports; internal registers hold.
- States:
  - IDLE: in_ready=0; start -> OP.
  - OP: in_ready=1; accept one opcode byte.
  - ARG: in_ready=1; collect remaining bytes.
  - EMIT: pix_valid=1, in_ready=0.
  - RUN: pix_valid=1, count>0.
  - DONE: done=1.
- start in any state forces OP and clears index, prev pixel, done, and any pending pixel; start has priority over every simultaneous event.
- Opcodes:
  - 0xFE RGB: next LIT_B bytes, MSB first, pixel right-aligned in 8*LIT_B bits; excess high bits ignored.
  - 0xFF EOF: -> DONE.
  - 00iiiiii INDEX: pixel = index[i mod 2**IDX_W].
  - 01rrggbb DIFF: each field minus 2 (range −2..+1) added to prev channel.
  - 10gggggg LUMA: dg = g−32; second byte {a,b}: dr = dg+a−8, db = dg+b−8.
  - 11nnnnnn (0xC0..0xFD) RUN: prev pixel repeated n+1 times (1..62).
- Arithmetic: channel additions are modulo 2**CW (wrap; no saturation). Deltas are sign-extended, then truncated to CW bits.
- Latency: pix_valid rises the cycle after the final byte of an op is accepted. pix_data holds stable while pix_valid=1 and pix_ready=0.
- On each pixel handshake:
  - prev ← pixel
  - index[(3r+5g+7b) mod 2**IDX_W] ← pixel
  - EMIT -> OP; RUN decrements count and goes to OP after the last repeat.
- RUN: one pixel per cycle while pix_ready=1; no input bytes accepted until the run completes.
- Throughput: at most one byte or one pixel per cycle; no byte accepted while a pixel is pending.
- Bytes offered in IDLE/DONE are not accepted (in_ready=0).
- busy=1 from start until DONE.

Test Plan (CW=4, IDX_W=6):
- Reset then start; bytes 0xFE,0x0F,0xA5 -> pix_data=12'hFA5, pix_valid one cycle after 0xA5 accepted; in_ready=0 while pending.
- After FA5, byte 0x79 (DIFF +1,0,−1) -> 12'h0A4 (red wraps F→0).
- After 0A4, bytes 0xA2,0x97 (LUMA dg=+2, dr=+3, db=+1) -> 12'h3C5.
- Byte 0xC2 with pix_ready pattern 1,0,1,1 -> exactly three 12'h3C5 handshakes, pix_data stable during the stall, in_ready=0 throughout the run.
- Byte 0x02 -> 12'hFA5 (hash 130 mod 64=2); byte 0x28 -> 12'h3C5 (hash 104 mod 64=40).
- Byte 0xFF -> done=1, busy=0, in_ready=0 next cycle. Then start followed by byte 0x02 -> 12'h000 (index cleared). rst_n low mid-literal -> all outputs reset within the same cycle. en=0 during RUN -> no handshakes occur and the count is preserved.
